// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-style bus between the fetch port and the data port.
// One transaction at a time. The data port has fixed priority. Bus outputs are registered
// and held for the whole transaction. Stall requests are combinational.
module sram_bus_arbiter #(
  parameter bit          ADDR_MAP_EN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  // fetch port
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        stallreq_if_o,
  // data port
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stallreq_mem_o,
  // external bus
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    StIdle,
    StIfBusy,
    StMemBusy,
    StDone
  } state_e;

  // Counter value seen in the last bus cycle the transaction is allowed to wait.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  tmo_cnt_q;
  logic        drop_q;

  logic        bus_ce_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_wdata_q;
  logic        bus_err_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ack_q;
  logic        mem_ack_q;

  logic [31:0] if_paddr;
  logic [31:0] mem_paddr;
  logic        timeout_hit;
  logic        bus_done;
  logic        drop_now;

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto the low 512 MiB of physical space.
  function automatic logic [31:0] map_addr(input logic [31:0] vaddr);
    logic [31:0] paddr;
    paddr = vaddr;
    if (ADDR_MAP_EN && (vaddr[31:30] == 2'b10)) begin
      paddr = {3'b000, vaddr[28:0]};
    end
    return paddr;
  endfunction

  // Physical addresses, transaction termination and fetch-drop decision.
  always_comb begin
    if_paddr    = map_addr(if_addr_i);
    mem_paddr   = map_addr(mem_addr_i);
    timeout_hit = (tmo_cnt_q == TimeoutLast);
    bus_done    = bus_ack_i | timeout_hit;
    // A flush in the terminating cycle itself also discards the fetch.
    drop_now    = drop_q | flush_i;
  end

  // Arbitration FSM with registered bus and port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      drop_q      <= 1'b0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      bus_err_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          tmo_cnt_q <= '0;
          drop_q    <= 1'b0;
          if (mem_ce_i) begin
            bus_ce_q    <= 1'b1;
            bus_we_q    <= mem_we_i;
            bus_addr_q  <= mem_paddr;
            bus_sel_q   <= mem_sel_i;
            bus_wdata_q <= mem_wdata_i;
            state_q     <= StMemBusy;
          end else if (if_ce_i) begin
            bus_ce_q    <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= if_paddr;
            bus_sel_q   <= 4'hF;
            bus_wdata_q <= '0;
            state_q     <= StIfBusy;
          end
        end

        StIfBusy: begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
          if (flush_i) begin
            drop_q <= 1'b1;
          end
          if (bus_done) begin
            bus_ce_q  <= 1'b0;
            bus_err_q <= ~bus_ack_i;
            tmo_cnt_q <= '0;
            drop_q    <= 1'b0;
            if (drop_now) begin
              // Flushed fetch: bus cycle completed, result discarded silently.
              state_q <= StIdle;
            end else begin
              if_rdata_q <= bus_ack_i ? bus_rdata_i : 32'h0;
              if_ack_q   <= 1'b1;
              state_q    <= StDone;
            end
          end
        end

        StMemBusy: begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
          if (bus_done) begin
            bus_ce_q    <= 1'b0;
            bus_err_q   <= ~bus_ack_i;
            tmo_cnt_q   <= '0;
            mem_rdata_q <= (bus_ack_i && !bus_we_q) ? bus_rdata_i : 32'h0;
            mem_ack_q   <= 1'b1;
            state_q     <= StDone;
          end
        end

        StDone: begin
          // No arbitration here: the served requester's ce is still high this cycle.
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output drive; a flush during the DONE cycle hides the fetch ack.
  always_comb begin
    bus_ce_o       = bus_ce_q;
    bus_we_o       = bus_we_q;
    bus_addr_o     = bus_addr_q;
    bus_sel_o      = bus_sel_q;
    bus_wdata_o    = bus_wdata_q;
    bus_err_o      = bus_err_q;
    if_rdata_o     = if_rdata_q;
    mem_rdata_o    = mem_rdata_q;
    if_ack_o       = if_ack_q & ~flush_i;
    mem_ack_o      = mem_ack_q;
    stallreq_if_o  = if_ce_i & ~if_ack_o;
    stallreq_mem_o = mem_ce_i & ~mem_ack_o;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a bus slave model answers the main instance, a
// scoreboard queue holds expected port results, and a second instance with a short
// timeout and a hand-driven bus covers the abort path.
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        stallreq_if_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        stallreq_mem_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_o;

  // Second instance (TIMEOUT_CYCLES=4), bus driven directly from the stimulus block.
  logic        t_flush = 1'b0;
  logic        t_if_ce = 1'b0;
  logic [31:0] t_if_addr = 32'h0;
  logic [31:0] t_if_rdata;
  logic        t_if_ack;
  logic        t_stall_if;
  logic        t_mem_ce;
  logic        t_mem_we = 1'b0;
  logic [31:0] t_mem_addr;
  logic [3:0]  t_mem_sel = 4'hF;
  logic [31:0] t_mem_wdata = 32'h0;
  logic [31:0] t_mem_rdata;
  logic        t_mem_ack;
  logic        t_stall_mem;
  logic        t_bus_ce;
  logic        t_bus_we;
  logic [31:0] t_bus_addr;
  logic [3:0]  t_bus_sel;
  logic [31:0] t_bus_wdata;
  logic [31:0] t_bus_rdata;
  logic        t_bus_ack;
  logic        t_bus_err;

  sram_bus_arbiter #(
    .ADDR_MAP_EN   (1'b1),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .if_ce_i       (if_ce_i),
    .if_addr_i     (if_addr_i),
    .if_rdata_o    (if_rdata_o),
    .if_ack_o      (if_ack_o),
    .stallreq_if_o (stallreq_if_o),
    .mem_ce_i      (mem_ce_i),
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_sel_i     (mem_sel_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_rdata_o   (mem_rdata_o),
    .mem_ack_o     (mem_ack_o),
    .stallreq_mem_o(stallreq_mem_o),
    .bus_ce_o      (bus_ce_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_sel_o     (bus_sel_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rdata_i   (bus_rdata_i),
    .bus_ack_i     (bus_ack_i),
    .bus_err_o     (bus_err_o)
  );

  sram_bus_arbiter #(
    .ADDR_MAP_EN   (1'b1),
    .TIMEOUT_CYCLES(4)
  ) dut_to (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (t_flush),
    .if_ce_i       (t_if_ce),
    .if_addr_i     (t_if_addr),
    .if_rdata_o    (t_if_rdata),
    .if_ack_o      (t_if_ack),
    .stallreq_if_o (t_stall_if),
    .mem_ce_i      (t_mem_ce),
    .mem_we_i      (t_mem_we),
    .mem_addr_i    (t_mem_addr),
    .mem_sel_i     (t_mem_sel),
    .mem_wdata_i   (t_mem_wdata),
    .mem_rdata_o   (t_mem_rdata),
    .mem_ack_o     (t_mem_ack),
    .stallreq_mem_o(t_stall_mem),
    .bus_ce_o      (t_bus_ce),
    .bus_we_o      (t_bus_we),
    .bus_addr_o    (t_bus_addr),
    .bus_sel_o     (t_bus_sel),
    .bus_wdata_o   (t_bus_wdata),
    .bus_rdata_i   (t_bus_rdata),
    .bus_ack_i     (t_bus_ack),
    .bus_err_o     (t_bus_err)
  );

  // Slave read data is a fixed function of the physical address.
  function automatic logic [31:0] resp(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Bus slave for the main instance: acks after ack_delay waiting cycles.
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  int   issued    = 0;
  logic ce_prev   = 1'b0;
  always @(negedge clk) begin
    if (bus_ce_o && !ce_prev) issued++;
    ce_prev = bus_ce_o;
    if (!bus_ce_o) begin
      bus_ack_i = 1'b0;
      wait_cnt  = 0;
    end else if (wait_cnt >= ack_delay) begin
      bus_ack_i   = 1'b1;
      bus_rdata_i = resp(bus_addr_o);
    end else begin
      bus_ack_i = 1'b0;
      wait_cnt++;
    end
  end

  typedef struct {
    bit          is_mem;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pop the oldest expectation and compare it with the port that just acked.
  task automatic sb_pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_port_is_mem"}, {31'b0, mem_ack_o}, {31'b0, e.is_mem});
      chk({tag, "_rdata"}, e.is_mem ? mem_rdata_o : if_rdata_o, e.rdata);
    end
  endtask

  task automatic wait_ack(input string tag, input int max_cycles);
    int n = 0;
    while (!(if_ack_o || mem_ack_o) && n < max_cycles) begin
      tick();
      n++;
    end
    chk({tag, "_ack_seen"}, {31'b0, (if_ack_o || mem_ack_o)}, 32'd1);
    if (if_ack_o || mem_ack_o) sb_pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b0; flush_i = 1'b0;
    if_ce_i = 1'b0; if_addr_i = '0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_wdata_i = '0;
    t_mem_ce = 1'b0; t_mem_addr = '0; t_bus_ack = 1'b0; t_bus_rdata = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_bus_ce", {31'b0, bus_ce_o}, 0);
    chk("rst_bus_we", {31'b0, bus_we_o}, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_sel", {28'b0, bus_sel_o}, 0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    chk("rst_bus_err", {31'b0, bus_err_o}, 0);
    chk("rst_acks", {30'b0, if_ack_o, mem_ack_o}, 0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 0);
    chk("rst_stalls", {30'b0, stallreq_if_o, stallreq_mem_o}, 0);
    chk("rst_to_bus_ce", {31'b0, t_bus_ce}, 0);
    rst = 1'b1;
    tick();

    // Single fetch through kseg1, ack in first bus cycle
    if_ce_i = 1'b1; if_addr_i = 32'hBFC0_0000;
    sb_q.push_back('{is_mem: 1'b0, rdata: resp(32'h1FC0_0000)});
    tick();
    chk("t1_bus_ce", {31'b0, bus_ce_o}, 1);
    chk("t1_bus_addr", bus_addr_o, 32'h1FC0_0000);
    chk("t1_bus_sel", {28'b0, bus_sel_o}, 32'hF);
    chk("t1_bus_we", {31'b0, bus_we_o}, 0);
    chk("t1_if_ack_early", {31'b0, if_ack_o}, 0);
    chk("t1_stall_if_busy", {31'b0, stallreq_if_o}, 1);
    tick();
    chk("t1_if_ack", {31'b0, if_ack_o}, 1);
    chk("t1_stall_if_ack", {31'b0, stallreq_if_o}, 0);
    chk("t1_bus_ce_drop", {31'b0, bus_ce_o}, 0);
    sb_pop_check("t1");
    if_ce_i = 1'b0;
    tick();
    chk("t1_if_ack_pulse", {31'b0, if_ack_o}, 0);

    // Simultaneous requests: data write first, then fetch
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8000_0010;
    mem_sel_i = 4'h3; mem_wdata_i = 32'h1234_5678;
    if_ce_i = 1'b1; if_addr_i = 32'hBFC0_0004;
    sb_q.push_back('{is_mem: 1'b1, rdata: 32'h0});
    sb_q.push_back('{is_mem: 1'b0, rdata: resp(32'h1FC0_0004)});
    tick();
    chk("t2_bus_addr", bus_addr_o, 32'h0000_0010);
    chk("t2_bus_we", {31'b0, bus_we_o}, 1);
    chk("t2_bus_sel", {28'b0, bus_sel_o}, 32'h3);
    chk("t2_bus_wdata", bus_wdata_o, 32'h1234_5678);
    chk("t2_stall_if_1", {31'b0, stallreq_if_o}, 1);
    tick();
    chk("t2_mem_ack", {31'b0, mem_ack_o}, 1);
    chk("t2_stall_mem", {31'b0, stallreq_mem_o}, 0);
    chk("t2_stall_if_2", {31'b0, stallreq_if_o}, 1);
    sb_pop_check("t2_mem");
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    tick();
    chk("t2_idle_gap", {31'b0, bus_ce_o}, 0);
    chk("t2_stall_if_3", {31'b0, stallreq_if_o}, 1);
    tick();
    chk("t2_if_bus_addr", bus_addr_o, 32'h1FC0_0004);
    chk("t2_if_bus_we", {31'b0, bus_we_o}, 0);
    chk("t2_if_bus_sel", {28'b0, bus_sel_o}, 32'hF);
    chk("t2_stall_if_4", {31'b0, stallreq_if_o}, 1);
    tick();
    sb_pop_check("t2_if");
    if_ce_i = 1'b0;
    tick();

    // Ack delayed 5 cycles; inputs changed after latch must not reach the bus
    ack_delay = 5; base = issued;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0100;
    mem_sel_i = 4'hF; mem_wdata_i = 32'h0;
    sb_q.push_back('{is_mem: 1'b1, rdata: resp(32'h0000_0100)});
    tick();
    mem_addr_i = 32'h0000_0F00; mem_we_i = 1'b1; mem_sel_i = 4'h1; mem_wdata_i = 32'hFFFF_0000;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_bus_ce_%0d", i), {31'b0, bus_ce_o}, 1);
      chk($sformatf("t3_bus_addr_%0d", i), bus_addr_o, 32'h0000_0100);
      chk($sformatf("t3_bus_we_sel_%0d", i), {27'b0, bus_we_o, bus_sel_o}, 32'h0F);
      chk($sformatf("t3_mem_ack_%0d", i), {31'b0, mem_ack_o}, 0);
      tick();
    end
    chk("t3_mem_ack", {31'b0, mem_ack_o}, 1);
    sb_pop_check("t3");
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    tick();
    chk("t3_single_pulse", {31'b0, mem_ack_o}, 0);
    chk("t3_one_txn", 32'(issued - base), 1);

    // Timeout instance: a normal read first so a later zero load is observable
    t_mem_ce = 1'b1; t_mem_addr = 32'hA000_0040;
    tick();
    chk("t4_bus_addr", t_bus_addr, 32'h0000_0040);
    t_bus_ack = 1'b1; t_bus_rdata = 32'hCAFE_F00D;
    tick();
    chk("t4_read_ack", {31'b0, t_mem_ack}, 1);
    chk("t4_read_rdata", t_mem_rdata, 32'hCAFE_F00D);
    t_bus_ack = 1'b0; t_mem_ce = 1'b0;
    tick();
    t_mem_ce = 1'b1; t_mem_addr = 32'hA000_0080;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_wait_ce_%0d", i), {31'b0, t_bus_ce}, 1);
      chk($sformatf("t4_wait_err_%0d", i), {30'b0, t_bus_err, t_mem_ack}, 0);
      tick();
    end
    chk("t4_ce_drop", {31'b0, t_bus_ce}, 0);
    chk("t4_bus_err", {31'b0, t_bus_err}, 1);
    chk("t4_mem_ack", {31'b0, t_mem_ack}, 1);
    chk("t4_rdata_zero", t_mem_rdata, 0);
    t_mem_ce = 1'b0;
    tick();
    chk("t4_err_pulse", {30'b0, t_bus_err, t_mem_ack}, 0);
    t_mem_ce = 1'b1; t_mem_addr = 32'h0000_0004;
    tick();
    chk("t4_back_idle", {31'b0, t_bus_ce}, 1);
    t_bus_ack = 1'b1; t_bus_rdata = 32'h5555_AAAA;
    tick();
    chk("t4_after_rdata", t_mem_rdata, 32'h5555_AAAA);
    t_bus_ack = 1'b0; t_mem_ce = 1'b0;
    tick();

    // Flush during IF_BUSY: result dropped, redirected fetch proceeds
    ack_delay = 2;
    if_ce_i = 1'b1; if_addr_i = 32'h0040_0000;
    tick();
    chk("t5_bus_addr", bus_addr_o, 32'h0040_0000);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; if_addr_i = 32'h0040_0100;
    chk("t5_no_ack_1", {31'b0, if_ack_o}, 0);
    tick();
    chk("t5_no_ack_2", {31'b0, if_ack_o}, 0);
    tick();
    chk("t5_no_ack_3", {31'b0, if_ack_o}, 0);
    chk("t5_rdata_kept", if_rdata_o, resp(32'h1FC0_0004));
    chk("t5_stall_if", {31'b0, stallreq_if_o}, 1);
    ack_delay = 0;
    sb_q.push_back('{is_mem: 1'b0, rdata: resp(32'h0040_0100)});
    tick();
    chk("t5_new_addr", bus_addr_o, 32'h0040_0100);
    tick();
    wait_ack("t5", 4);
    if_ce_i = 1'b0;
    tick();

    // Flush in DONE hides the fetch ack
    if_ce_i = 1'b1; if_addr_i = 32'h0040_0200;
    repeat (2) tick();
    chk("t5b_ack_before", {31'b0, if_ack_o}, 1);
    flush_i = 1'b1; if_ce_i = 1'b0;
    #1;
    chk("t5b_ack_hidden", {31'b0, if_ack_o}, 0);
    tick();
    flush_i = 1'b0;
    tick();

    // Reset in MEM_BUSY abandons the transaction
    ack_delay = 10;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0200; mem_sel_i = 4'hF;
    tick();
    chk("t6_busy_1", {31'b0, bus_ce_o}, 1);
    tick();
    chk("t6_busy_2", {31'b0, bus_ce_o}, 1);
    rst = 1'b0;
    tick();
    chk("t6_ce_low", {31'b0, bus_ce_o}, 0);
    chk("t6_acks_low", {30'b0, if_ack_o, mem_ack_o}, 0);
    chk("t6_rdata_clear", mem_rdata_o, 0);
    chk("t6_addr_clear", bus_addr_o, 0);
    rst = 1'b1; ack_delay = 0; mem_addr_i = 32'h0000_0300;
    sb_q.push_back('{is_mem: 1'b1, rdata: resp(32'h0000_0300)});
    tick();
    chk("t6_fresh_addr", bus_addr_o, 32'h0000_0300);
    tick();
    wait_ack("t6", 3);
    mem_ce_i = 1'b0;
    tick();

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one external SRAM-style bus between the instruction-fetch port (driven by the PC stage) and the data port (MEM stage).
- Applies the kseg0/kseg1 physical address mapping.
- Runs one transaction at a time with a req/ack handshake.
- Raises per-port stall requests toward the pipeline controller until each port's access completes.

Parameters:
- ADDR_MAP_EN, 1, when 1, addresses with addr[31:30]==2'b10 have bits [31:29] cleared before going to the bus; when 0, addresses pass through unchanged.
- TIMEOUT_CYCLES, 255, maximum cycles a bus transaction waits for bus_ack_i before it is aborted (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising edge of clk)
- flush_i  in  1  pipeline flush; discards an in-flight fetch result
- if_ce_i  in  1  fetch request
- if_addr_i  in  32  fetch virtual address (PC)
- if_rdata_o  out  32  fetched instruction, registered
- if_ack_o  out  1  one-cycle pulse: if_rdata_o valid
- stallreq_if_o  out  1  fetch stall request
- mem_ce_i  in  1  data request
- mem_we_i  in  1  1 = write
- mem_addr_i  in  32  data virtual address
- mem_sel_i  in  4  byte enables
- mem_wdata_i  in  32  write data
- mem_rdata_o  out  32  read data, registered
- mem_ack_o  out  1  one-cycle pulse: data access complete
- stallreq_mem_o  out  1  data stall request
- bus_ce_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  physical address
- bus_sel_o  out  4  byte enables (4'b1111 for fetch)
- bus_wdata_o  out  32  write data
- bus_rdata_i  in  32  read data, valid with ack
- bus_ack_i  in  1  transaction complete
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst==0):
  - State goes to IDLE; the timeout counter and the drop flag clear.
  - All outputs are 0: bus_*, *_rdata_o, *_ack_o, bus_err_o. The stallreq outputs follow their combinational equations.
  - Reset mid-transaction abandons the transaction; bus_ce_o is low from the next cycle onward.
- FSM has four states: IDLE, IF_BUSY, MEM_BUSY, DONE.
- IDLE:
  - If mem_ce_i: latch the data request and go to MEM_BUSY.
  - Else if if_ce_i: latch the fetch request and go to IF_BUSY.
  - Data port has fixed priority over fetch.
  - Bus outputs are registered, so bus_ce_o rises one cycle after the request is sampled.
- IF_BUSY / MEM_BUSY:
  - bus_ce_o=1 and all bus_* outputs are held stable from registers until termination.
  - The timeout counter increments every cycle in these states.
  - Normal termination: on bus_ack_i=1, capture bus_rdata_i into the port's rdata register (writes load 0 into mem_rdata_o), drop bus_ce_o, go to DONE.
  - Timeout termination: when the counter reaches TIMEOUT_CYCLES with no ack, pulse bus_err_o, load 0 into the port's rdata, go to DONE.
  - No preemption: a mem request arriving during IF_BUSY waits for the fetch to finish.
  - Input changes after the request is latched have no effect on the bus.
- DONE (one cycle):
  - Pulse the served port's *_ack_o, then go to IDLE.
  - No new arbitration happens in DONE. The requester's ce is still high for the same instruction, so this prevents re-issue.
- Stall equations (combinational):
  - stallreq_mem_o = mem_ce_i & ~mem_ack_o.
  - stallreq_if_o = if_ce_i & ~if_ack_o.
- Flush:
  - flush_i in IF_BUSY sets the drop flag. On termination, go straight to IDLE with no if_ack_o and no rdata update. The bus transaction itself is never cut short.
  - flush_i in IDLE or DONE has no effect on state, except that a DONE-cycle if_ack_o is suppressed when flush_i=1.
  - flush_i never affects data transactions.
- Address map (ADDR_MAP_EN=1): 0x8000_0000..0xBFFF_FFFF maps to {3'b000, addr[28:0]}; all other addresses pass through.
- Latency: a request whose ack comes in the first bus cycle completes with *_ack_o three cycles after the request is sampled (sample, bus, DONE). The pipeline advances at the end of the ack cycle.
- Simultaneous requests: the data access is served first, then the fetch (still asserted) is sampled in the IDLE that follows DONE.
- Back-to-back requests from one port: there is at least one IDLE cycle between transactions.

Test Plan:
- Single fetch: if_addr_i=0xBFC0_0000, ack in first bus cycle -> bus_addr_o=0x1FC0_0000, bus_sel_o=4'hF; if_ack_o pulses 3 cycles after request with if_rdata_o=bus_rdata_i; stallreq_if_o high until the ack cycle.
- Simultaneous if_ce_i/mem_ce_i: write 0x1234_5678 to 0x8000_0010, sel=4'h3 -> data served first (bus_addr_o=0x0000_0010, bus_we_o=1), then fetch; stallreq_if_o stays high across both transactions.
- Ack delay: ack delayed 5 cycles -> bus outputs stable throughout, single mem_ack_o pulse, exactly one bus transaction issued.
- Timeout: no ack, TIMEOUT_CYCLES=4 -> bus_err_o pulses after 4 bus cycles, mem_rdata_o=0, mem_ack_o pulses, FSM returns to IDLE.
- Flush: flush_i asserted during IF_BUSY -> no if_ack_o, if_rdata_o unchanged, next fetch of the new address proceeds normally.
- Reset: rst=0 mid MEM_BUSY -> next cycle bus_ce_o=0 and all acks 0; after rst=1, a fresh request completes normally.
